// File: rtl/tartaruga_pkg.sv
// Shared MEM-stage data-memory types, constants and the byte-enable legality rule.
package tartaruga_pkg;

  localparam int unsigned DMEM_ADDR_W  = 32;
  localparam int unsigned DMEM_DATA_W  = 32;
  localparam int unsigned DMEM_BE_W    = 4;
  localparam int unsigned DMEM_LFSR_W  = 16;

  // Stall-injection LFSR: seed and right-shift Galois mask for x^16+x^14+x^13+x^11+1.
  localparam logic [DMEM_LFSR_W-1:0] DMEM_LFSR_SEED = 16'hACE1;
  localparam logic [DMEM_LFSR_W-1:0] DMEM_LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic                   we;
    logic [DMEM_BE_W-1:0]   be;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DMEM_DATA_W-1:0] rdata;
    logic                   err;
    logic                   we;
  } dmem_rsp_t;

  // Naturally aligned byte, halfword or word enables relative to the byte offset.
  function automatic logic dmem_be_legal(input logic [1:0] addr_lo, input logic [3:0] be);
    logic legal;
    legal = 1'b0;
    case (be)
      4'b0001: legal = (addr_lo == 2'd0);
      4'b0010: legal = (addr_lo == 2'd1);
      4'b0100: legal = (addr_lo == 2'd2);
      4'b1000: legal = (addr_lo == 2'd3);
      4'b0011: legal = (addr_lo == 2'd0);
      4'b1100: legal = (addr_lo == 2'd2);
      4'b1111: legal = (addr_lo == 2'd0);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Show-ahead response FIFO: head_o is valid whenever empty_o is low; push and pop may share a cycle.
module dmem_rsp_fifo
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  input  logic      push_i,
  input  dmem_rsp_t push_data_i,
  input  logic      pop_i,
  output dmem_rsp_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dmem_rsp_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy update; a push into a full FIFO is taken only alongside a pop.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; only entries between the pointers are ever observed, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store channel: fixed-latency, in-order,
// bounded-outstanding responses. Optional DMEM_STALL_INJECT_EN adds LFSR-driven req_ready_o stalls.
module dmem_responder
  import tartaruga_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_we_o,
  output logic        busy_o
);

  localparam int unsigned IW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW         = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  dmem_req_t                 req;
  dmem_rsp_t                 rsp_new;
  logic                      legal;
  logic                      accept;
  logic                      stall;
  logic [IW-1:0]             word_idx;
  logic [31:0]               mem_q [MEM_WORDS];

  logic [LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
  dmem_rsp_t [LATENCY-1:0]   pipe_rsp_q, pipe_rsp_d;
  logic                      pipe_out_vld;
  dmem_rsp_t                 pipe_out;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_empty;
  logic                      fifo_full;
  dmem_rsp_t                 fifo_head;
  dmem_rsp_t                 rsp_sel;
  logic                      retire;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      busy_q, busy_d;

  // Request decode, legality and the load word sampled on the acceptance edge.
  always_comb begin
    req.addr      = req_addr_i;
    req.we        = req_we_i;
    req.be        = req_be_i;
    req.wdata     = req_wdata_i;
    word_idx      = req.addr[IW+1:2];
    legal         = (req.addr < ADDR_LIMIT) && dmem_be_legal(req.addr[1:0], req.be);
    accept        = req_valid_i && req_ready_o;
    rsp_new.rdata = (legal && !req.we) ? mem_q[word_idx] : 32'h0;
    rsp_new.err   = !legal;
    rsp_new.we    = req.we;
  end

  // Byte-lane write of legal stores; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && legal && req.we) begin
      for (int i = 0; i < 4; i++) begin
        if (req.be[i]) begin
          mem_q[word_idx][8*i +: 8] <= req.wdata[8*i +: 8];
        end
      end
    end
  end

  // Latency pipeline: stage 0 captures the accepted response, later stages shift every cycle.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_rsp_d    = pipe_rsp_q;
    pipe_vld_d[0] = accept;
    pipe_rsp_d[0] = accept ? rsp_new : '0;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_rsp_d[k] = pipe_rsp_q[k-1];
    end
  end

  // Pipeline registers; invalid stages are cleared so idle outputs read as zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pipe_vld_q <= '0;
      pipe_rsp_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_rsp_q <= pipe_rsp_d;
    end
  end

  // Pipeline output bypasses an empty FIFO; anything not taken immediately is parked in order.
  always_comb begin
    pipe_out_vld = pipe_vld_q[LATENCY-1];
    pipe_out     = pipe_rsp_q[LATENCY-1];
    fifo_push    = pipe_out_vld && !(fifo_empty && rsp_ready_i);
    fifo_pop     = !fifo_empty && rsp_ready_i;
    rsp_sel      = fifo_empty ? pipe_out : fifo_head;
    retire       = (!fifo_empty || pipe_out_vld) && rsp_ready_i;
  end

  dmem_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (fifo_push),
    .push_data_i (pipe_out),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Outstanding count: accepted but not yet response-handshaken.
  always_comb begin
    cnt_d  = cnt_q + CW'(accept) - CW'(retire);
    busy_d = (cnt_d != '0);
  end

  // Outstanding counter and busy flag registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

`ifdef DMEM_STALL_INJECT_EN
  logic [DMEM_LFSR_W-1:0] lfsr_q, lfsr_d;

  // Galois LFSR step, free-running every cycle.
  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ DMEM_LFSR_TAPS) : (lfsr_q >> 1);
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= DMEM_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign req_ready_o = (cnt_q < CW'(MAX_OUTSTANDING)) && !stall;
  assign rsp_valid_o = !fifo_empty || pipe_out_vld;
  assign rsp_rdata_o = rsp_sel.rdata;
  assign rsp_err_o   = rsp_sel.err;
  assign rsp_we_o    = rsp_sel.we;
  assign busy_o      = busy_q;

  // The outstanding bound guarantees the FIFO always has room for the pipeline output.
  assert property (@(posedge clk_i) disable iff (!rstn_i) !(fifo_push && fifo_full && !fifo_pop));
  assert property (@(posedge clk_i) disable iff (!rstn_i) cnt_q <= CW'(MAX_OUTSTANDING));

endmodule
